// File: rtl/f1_reaction_timer.sv
// rtl/f1_reaction_timer.sv - F1 start-light reaction timer with false-start and timeout detection
module f1_reaction_timer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  a0,
  input  logic                   button,
  output logic [COUNT_WIDTH-1:0] reaction_time,
  output logic                   valid,
  output logic                   false_start,
  output logic                   timeout,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMING,
    S_ARMED,
    S_TIMING,
    S_HOLD
  } state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   sync_out;
  logic                   press;
  logic [COUNT_WIDTH-1:0] cnt, cnt_d;
  logic [COUNT_WIDTH-1:0] reaction_time_d;
  logic                   valid_d, false_start_d, timeout_d;
  logic [7:0]             lights;
  logic                   full, dark, cnt_sat;
  logic                   unused_a0;

  assign lights    = a0[7:0];
  assign unused_a0 = ^a0[DATA_WIDTH-1:8];
  assign full      = (lights == 8'hFF);
  assign dark      = (lights == 8'h00);
  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign press     = sync_out & ~sync_prev;
  assign cnt_sat   = (cnt == {COUNT_WIDTH{1'b1}});

  // Button enters on bit 0 and emerges at the top after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], button};
      sync_prev <= sync_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      reaction_time <= '0;
      valid         <= 1'b0;
      false_start   <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      reaction_time <= reaction_time_d;
      valid         <= valid_d;
      false_start   <= false_start_d;
      timeout       <= timeout_d;
      busy          <= (state_d == S_TIMING);
    end
  end

  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    reaction_time_d = reaction_time;
    valid_d         = 1'b0;
    false_start_d   = false_start;
    timeout_d       = timeout;
    case (state)
      S_IDLE: begin
        if (!dark) begin
          state_d       = S_ARMING;
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_ARMING, S_ARMED: begin
        if (press) begin
          state_d         = S_HOLD;
          false_start_d   = 1'b1;
          reaction_time_d = '0;
          valid_d         = 1'b1;
        end else if (state == S_ARMING) begin
          if (full)
            state_d = S_ARMED;
          else if (dark)
            state_d = S_IDLE;
        end else if (dark) begin
          // Only a full bar going fully dark counts as lights-out.
          state_d = S_TIMING;
          cnt_d   = '0;
        end
      end
      S_TIMING: begin
        if (press) begin
          state_d         = S_HOLD;
          reaction_time_d = cnt;
          valid_d         = 1'b1;
        end else if (cnt_sat) begin
          state_d         = S_HOLD;
          reaction_time_d = {COUNT_WIDTH{1'b1}};
          timeout_d       = 1'b1;
          valid_d         = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        // Released button and a dark bar must coincide before re-arming.
        if (!sync_out && dark)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb/tb_f1_reaction_timer.sv - scoreboard bench for f1_reaction_timer
module tb_f1_reaction_timer;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a0;
  logic          button;
  logic [CW-1:0] reaction_time;
  logic          valid, false_start, timeout, busy;

  typedef struct {
    logic [CW-1:0] rt;
    logic          fs;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_pushed = 0;
  logic valid_prev = 1'b0;

  f1_reaction_timer #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .a0           (a0),
    .button       (button),
    .reaction_time(reaction_time),
    .valid        (valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] rt, input logic fs, input logic to);
    exp_t e;
    e.rt = rt;
    e.fs = fs;
    e.to = to;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic ramp_to(input logic [7:0] last);
    logic [7:0] v;
    v = 8'h00;
    while (v != last) begin
      v = {v[6:0], 1'b1};
      a0 = {24'h0, v};
      tick(3);
    end
  endtask

  // Lights out at the next edge (E0); raw button rises between E0+n-1 and E0+n.
  task automatic timed_press(input int n);
    a0 = 32'h0;
    push(CW'(n + SS - 1), 1'b0, 1'b0);
    tick(n);
    button = 1'b1;
    tick(6);
    button = 1'b0;
    tick(5);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (valid) begin
        exp_t e;
        n_valid++;
        check("valid_b2b", {31'h0, valid_prev}, 32'h0);
        check("fs_to_excl", {31'h0, false_start & timeout}, 32'h0);
        if (sb.size() == 0) begin
          check("spurious_valid", {31'h0, valid}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("reaction_time", {24'h0, reaction_time}, {24'h0, e.rt});
          check("false_start", {31'h0, false_start}, {31'h0, e.fs});
          check("timeout", {31'h0, timeout}, {31'h0, e.to});
        end
      end
      valid_prev <= valid;
    end else begin
      valid_prev <= 1'b0;
    end
  end

  initial begin
    rst    = 1'b0;
    a0     = 32'h0;
    button = 1'b0;
    tick(3);
    check("rst_rt", {24'h0, reaction_time}, 32'h0);
    check("rst_flags", {28'h0, valid, false_start, timeout, busy}, 32'h0);
    rst = 1'b1;
    tick(2);

    // Normal reaction, N=100
    ramp_to(8'hFF);
    tick(2);
    timed_press(100);

    // False start at 0x0F; held through lights-out must not start timing
    ramp_to(8'h0F);
    push(8'h00, 1'b1, 1'b0);
    button = 1'b1;
    tick(3);
    a0 = 32'h1F;
    tick(3);
    a0 = 32'hFF;
    tick(3);
    a0 = 32'h0;
    tick(5);
    check("fs_no_busy", {31'h0, busy}, 32'h0);
    button = 1'b0;
    tick(6);

    // Aborted sequence then normal measurement
    ramp_to(8'h07);
    a0 = 32'h0;
    tick(6);
    check("abort_busy", {31'h0, busy}, 32'h0);
    ramp_to(8'hFF);
    timed_press(37);

    // Timeout at counter saturation
    ramp_to(8'hFF);
    a0 = 32'h0;
    push(8'hFF, 1'b0, 1'b1);
    tick(3);
    check("to_busy", {31'h0, busy}, 32'h1);
    tick(270);
    check("to_done_busy", {31'h0, busy}, 32'h0);
    check("to_sticky", {31'h0, timeout}, 32'h1);

    // Asynchronous reset in the middle of timing
    ramp_to(8'hFF);
    a0 = 32'h0;
    tick(51);
    check("mid_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    check("arst_rt", {24'h0, reaction_time}, 32'h0);
    check("arst_flags", {28'h0, valid, false_start, timeout, busy}, 32'h0);
    tick(3);
    rst = 1'b1;
    tick(2);
    ramp_to(8'hFF);
    timed_press(20);

    // Press held since ARMED, then bounce after lights-out
    ramp_to(8'hFF);
    push(8'h00, 1'b1, 1'b0);
    button = 1'b1;
    tick(4);
    a0 = 32'h0;
    tick(8);
    button = 1'b0; tick(2);
    button = 1'b1; tick(2);
    button = 1'b0; tick(1);
    button = 1'b1; tick(1);
    button = 1'b0; tick(6);
    check("bounce_busy", {31'h0, busy}, 32'h0);

    // Bounce after a valid timed press
    ramp_to(8'hFF);
    a0 = 32'h0;
    push(8'd11, 1'b0, 1'b0);
    tick(10);
    button = 1'b1; tick(3);
    button = 1'b0; tick(1);
    button = 1'b1; tick(2);
    button = 1'b0; tick(1);
    button = 1'b1; tick(1);
    button = 1'b0; tick(8);

    check("sb_drain", sb.size(), 32'h0);
    check("valid_count", n_valid, n_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
